dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared encodings and lane-steering helpers for dmem_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: byte_en = 4'b0001 << lane;
            MEM_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: byte_en = 4'b1111;
            default:  byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            MEM_BYTE: store_data = {4{wdata[7:0]}};
            MEM_HALF: store_data = {2{wdata[15:0]}};
            default:  store_data = wdata;
        endcase
    endfunction

    // Little-endian lane extraction, zero-filled above the access width.
    function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] word);
        logic [31:0] sh;
        sh = 32'd0;
        case (size)
            MEM_BYTE: begin
                sh        = word >> {lane, 3'b000};
                load_data = {24'd0, sh[7:0]};
            end
            MEM_HALF: begin
                sh        = word >> {lane[1], 4'b0000};
                load_data = {16'd0, sh[15:0]};
            end
            MEM_WORD: load_data = word;
            default:  load_data = 32'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_HALF: misaligned = lane[0];
            MEM_WORD: misaligned = |lane;
            default:  misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module  : dmem_array
// Brief   : Single-port word RAM, four byte enables, registered read, no reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (be[i]) begin
                    mem[addr] <= wdata[8*i +: 8];
                end
                q <= mem[addr];
            end
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder: request FSM, error checks, lane steering.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_read_i,
    input  logic [1:0]  req_write_i,
    output logic        busy_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         DIRECT   = (LATENCY == 0);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_write;
    logic                  r_err;
    logic [31:0]           r_wdata;

    logic                  w_rd_any;
    logic                  w_wr_any;
    logic                  w_req;
    logic [1:0]            w_size;
    logic [30:0]           w_wdiff;
    logic                  w_range_err;
    logic                  w_err;

    logic                  w_ram_en;
    logic [3:0]            w_ram_be;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic [31:0]           w_ram_rdata;

    assign w_rd_any = |req_read_i;
    assign w_wr_any = |req_write_i;
    assign w_req    = w_rd_any | w_wr_any;
    assign w_size   = w_rd_any ? req_read_i : req_write_i;

    // Word-granular offset from the base; BASE_ADDR is expected to be word-aligned.
    assign w_wdiff     = {1'b0, req_addr_i[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign w_range_err = w_wdiff[30] | (|w_wdiff[29:ADDR_WIDTH]);
    assign w_err       = (w_rd_any & w_wr_any) | w_range_err | misaligned(w_size, req_addr_i[1:0]);

    // Zero latency accesses straight from the request; otherwise from the captured copy.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_be    = 4'b0000;
        w_ram_addr  = r_idx;
        w_ram_wdata = store_data(r_size, r_wdata);
        if (DIRECT) begin
            w_ram_addr  = w_wdiff[ADDR_WIDTH-1:0];
            w_ram_wdata = store_data(w_size, req_wdata_i);
            if (r_state == ST_IDLE && w_req && !w_err) begin
                w_ram_en = n_rst_i;
                w_ram_be = w_wr_any ? byte_en(w_size, req_addr_i[1:0]) : 4'b0000;
            end
        end else if (r_state == ST_WAIT && r_cnt == 4'd0 && !r_err) begin
            w_ram_en = n_rst_i;
            w_ram_be = r_write ? byte_en(r_size, r_lane) : 4'b0000;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk_i),
        .en    (w_ram_en),
        .be    (w_ram_be),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_lane      <= 2'd0;
            r_size      <= MEM_NONE;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= 32'd0;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            busy_o      <= (r_state == ST_WAIT);
            rsp_valid_o <= (r_state == ST_RESP);
            rsp_err_o   <= (r_state == ST_RESP) && r_err;
            rsp_rdata_o <= (r_state == ST_RESP && !r_err && !r_write)
                           ? load_data(r_size, r_lane, w_ram_rdata) : 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_wdiff[ADDR_WIDTH-1:0];
                        r_lane  <= req_addr_i[1:0];
                        r_size  <= w_size;
                        r_write <= w_wr_any;
                        r_err   <= w_err;
                        r_wdata <= req_wdata_i;
                        r_cnt   <= LAT_LOAD;
                        r_state <= DIRECT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed table-driven bench for dmem_responder at LATENCY 2 and 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  rd   [2];
    logic [1:0]  wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic        busy [2];
    logic        vld  [2];
    logic [31:0] rdt  [2];
    logic        err  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Index 0: LATENCY 0, index 1: LATENCY 2.
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk_i (clk), .n_rst_i (n_rst),
        .req_addr_i (ad[0]), .req_wdata_i (wd[0]), .req_read_i (rd[0]), .req_write_i (wr[0]),
        .busy_o (busy[0]), .rsp_valid_o (vld[0]), .rsp_rdata_o (rdt[0]), .rsp_err_o (err[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk_i (clk), .n_rst_i (n_rst),
        .req_addr_i (ad[1]), .req_wdata_i (wd[1]), .req_read_i (rd[1]), .req_write_i (wr[1]),
        .busy_o (busy[1]), .rsp_valid_o (vld[1]), .rsp_rdata_o (rdt[1]), .rsp_err_o (err[1])
    );

    typedef struct {
        int          d;
        logic [1:0]  r;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wdat;
        logic [31:0] exp;
        logic        e;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input int d, input logic [1:0] r, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] wdat, input logic [31:0] exp, input logic e);
        vec_t v;
        v.d = d; v.r = r; v.w = w; v.a = a; v.wdat = wdat; v.exp = exp; v.e = e;
        vt.push_back(v);
    endtask

    // One request: checks response cycle, data, error flag, busy shape and pulse width.
    task automatic run_req(input int d, input logic [1:0] r, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wdat, input logic [31:0] exp, input logic e,
                           input string nm);
        int lat;
        bit got;
        bit busy_ok;
        lat     = (d == 1) ? 2 : 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = wdat;
        @(posedge clk);
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rd[d] = 2'b00; wr[d] = 2'b00;
            end
            if (busy[d] !== ((c >= 1 && c <= lat) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (vld[d] === 1'b1) begin
                got = 1'b1;
                chk({nm, " latency"}, c, lat + 1);
                chk({nm, " rdata"}, rdt[d], exp);
                chk({nm, " err"}, {31'd0, err[d]}, {31'd0, e});
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_response required=response", nm);
        end
        chk({nm, " busy_shape"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        chk({nm, " pulse_width"}, {31'd0, vld[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int npulse;
        bit busy_seen;
        bit data_ok;
        bit vld_seen;

        n_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 2'b00; wr[i] = 2'b00; ad[i] = 32'd0; wd[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_outputs%0d", i), {busy[i], vld[i], err[i], 29'd0} | rdt[i], 32'd0);
        end
        n_rst = 1'b1;

        // LATENCY 2 table
        add(1, 2'b00, 2'b11, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0);
        add(1, 2'b11, 2'b00, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
        add(1, 2'b00, 2'b01, 32'h13,       32'h1234565A, 32'h0,        1'b0);
        add(1, 2'b01, 2'b00, 32'h13,       32'h0,        32'h0000005A, 1'b0);
        add(1, 2'b11, 2'b00, 32'h10,       32'h0,        32'h5AADBEEF, 1'b0);
        add(1, 2'b10, 2'b00, 32'h12,       32'h0,        32'h00005AAD, 1'b0);
        add(1, 2'b10, 2'b00, 32'h11,       32'h0,        32'h0,        1'b1);
        add(1, 2'b11, 2'b00, 32'h10,       32'h0,        32'h5AADBEEF, 1'b0);
        add(1, 2'b00, 2'b11, 32'h0,        32'h11223344, 32'h0,        1'b0);
        add(1, 2'b00, 2'b11, 32'h1000,     32'hAAAAAAAA, 32'h0,        1'b1);
        add(1, 2'b11, 2'b00, 32'h0,        32'h0,        32'h11223344, 1'b0);
        add(1, 2'b11, 2'b11, 32'h10,       32'h0,        32'h0,        1'b1);
        add(1, 2'b11, 2'b00, 32'h10,       32'h0,        32'h5AADBEEF, 1'b0);
        add(1, 2'b00, 2'b11, 32'h14,       32'h01020304, 32'h0,        1'b0);
        add(1, 2'b00, 2'b10, 32'h16,       32'hFFFFBEEF, 32'h0,        1'b0);
        add(1, 2'b11, 2'b00, 32'h14,       32'h0,        32'hBEEF0304, 1'b0);
        add(1, 2'b10, 2'b00, 32'h14,       32'h0,        32'h00000304, 1'b0);
        add(1, 2'b01, 2'b00, 32'h15,       32'h0,        32'h00000003, 1'b0);
        add(1, 2'b00, 2'b11, 32'h12,       32'h55555555, 32'h0,        1'b1);
        add(1, 2'b11, 2'b00, 32'h10,       32'h0,        32'h5AADBEEF, 1'b0);
        add(1, 2'b00, 2'b11, 32'hFFC,      32'hCAFEF00D, 32'h0,        1'b0);
        add(1, 2'b11, 2'b00, 32'hFFC,      32'h0,        32'hCAFEF00D, 1'b0);
        add(1, 2'b01, 2'b00, 32'h80000010, 32'h0,        32'h0,        1'b1);
        // LATENCY 0 table
        add(0, 2'b00, 2'b11, 32'h40,       32'h0BADCAFE, 32'h0,        1'b0);
        add(0, 2'b11, 2'b00, 32'h40,       32'h0,        32'h0BADCAFE, 1'b0);
        add(0, 2'b01, 2'b00, 32'h41,       32'h0,        32'h000000CA, 1'b0);
        add(0, 2'b10, 2'b00, 32'h42,       32'h0,        32'h00000BAD, 1'b0);
        add(0, 2'b00, 2'b10, 32'h43,       32'hFFFF1111, 32'h0,        1'b1);
        add(0, 2'b11, 2'b00, 32'h40,       32'h0,        32'h0BADCAFE, 1'b0);

        foreach (vt[i]) begin
            run_req(vt[i].d, vt[i].r, vt[i].w, vt[i].a, vt[i].wdat, vt[i].exp, vt[i].e,
                    $sformatf("vec%0d", i));
        end

        // LATENCY 0: a read held for 8 edges is accepted on every IDLE edge -> 4 responses.
        npulse    = 0;
        busy_seen = 1'b0;
        data_ok   = 1'b1;
        @(negedge clk);
        rd[0] = 2'b11; ad[0] = 32'h40;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy[0] === 1'b1) busy_seen = 1'b1;
            if (vld[0] === 1'b1) begin
                npulse++;
                if (rdt[0] !== 32'h0BADCAFE) data_ok = 1'b0;
            end
            if (c == 7) rd[0] = 2'b00;
        end
        chk("held_req_pulses", npulse, 4);
        chk("held_req_data", {31'd0, data_ok}, 32'd1);
        chk("held_req_busy", {31'd0, busy_seen}, 32'd0);

        // LATENCY 2: reset in WAIT before the access cycle drops the write.
        run_req(1, 2'b00, 2'b11, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, "pre_reset_write");
        @(negedge clk);
        wr[1] = 2'b11; ad[1] = 32'h20; wd[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        wr[1] = 2'b00;
        n_rst = 1'b0;
        vld_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (vld[1] === 1'b1) vld_seen = 1'b1;
        end
        chk("mid_reset_outputs", {busy[1], vld[1], err[1], 29'd0} | rdt[1], 32'd0);
        n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (vld[1] === 1'b1) vld_seen = 1'b1;
        end
        chk("mid_reset_no_rsp", {31'd0, vld_seen}, 32'd0);
        run_req(1, 2'b11, 2'b00, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, "post_reset_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
